// File: rtl/outfifo_ctrl_pkg.sv
// Shared types and constants for the output-FIFO access controller.
package outfifo_ctrl_pkg;

    localparam int DEFAULT_TIMEOUT = 8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ISSUE_WR = 4'd1,
        ST_ISSUE_RD = 4'd2,
        ST_WAIT     = 4'd3,
        ST_RESP     = 4'd4,
        ST_GAP      = 4'd5
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer only moves on a tie so a
// lone requester never steals the other's turn.
module rr_arb2
    import outfifo_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic req_wr_i,
    input  logic req_rd_i,
    output gnt_t gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection; ptr_q = 0 favours the writer on a tie.
    always_comb begin
        gnt_o = GNT_NONE;
        ptr_d = ptr_q;
        if (en_i) begin
            if (req_wr_i && req_rd_i) begin
                gnt_o = ptr_q ? GNT_RD : GNT_WR;
                ptr_d = ~ptr_q;
            end else if (req_wr_i) begin
                gnt_o = GNT_WR;
            end else if (req_rd_i) begin
                gnt_o = GNT_RD;
            end else begin
                gnt_o = GNT_NONE;
            end
        end else begin
            gnt_o = GNT_NONE;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/outfifo_access_ctrl.sv
// Shares the bit-serial output FIFO between the CDR writer and CPU reader,
// turning strobes/levels into edge-style enables with timeout and status.
module outfifo_access_ctrl
    import outfifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int TMO_BITS   = 4
) (
    input  logic                  inClock,
    input  logic                  inReset,
    input  logic                  inBitValid,
    input  logic                  inBit,
    input  logic                  inRdReq,
    input  logic                  inClearErr,
    input  logic                  inFifoDone,
    input  logic                  inFifoFull,
    input  logic                  inFifoEmpty,
    input  logic [DATA_WIDTH-1:0] inFifoData,
    output logic                  outFifoWrEn,
    output logic                  outFifoRdEn,
    output logic                  outFifoBit,
    output logic                  outRdAck,
    output logic                  outRdErr,
    output logic [DATA_WIDTH-1:0] outRdData,
    output logic                  outBitOverrun,
    output logic [7:0]            outWrErrCnt,
    output logic                  outBusy
);

    localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic                  op_rd_q, op_rd_d;
    logic [TMO_BITS-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic                  hold_full_q, hold_full_d;
    logic                  hold_bit_q, hold_bit_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  fifo_bit_q, fifo_bit_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  rd_err_q, rd_err_d;
    logic                  rd_fail_q, rd_fail_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  overrun_q, overrun_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  busy_q, busy_d;

    logic                  arb_en_s;
    logic                  req_rd_s;
    gnt_t                  gnt_s;
    logic                  hold_consume_s;
    logic                  wr_fail_s;
    logic                  bit_take_s;
    logic                  bit_drop_s;

    assign req_rd_s = inRdReq & ~rd_ack_q;

    rr_arb2 u_arb (
        .clk_i    (inClock),
        .rst_ni   (inReset),
        .en_i     (arb_en_s),
        .req_wr_i (hold_full_q),
        .req_rd_i (req_rd_s),
        .gnt_o    (gnt_s)
    );

    // Sequencer: grant, issue, wait for done/timeout, respond, re-arm gap.
    always_comb begin
        state_d        = state_q;
        op_rd_d        = op_rd_q;
        tmo_cnt_d      = '0;
        wr_en_d        = wr_en_q;
        rd_en_d        = rd_en_q;
        fifo_bit_d     = fifo_bit_q;
        rd_data_d      = rd_data_q;
        rd_fail_d      = rd_fail_q;
        hold_consume_s = 1'b0;
        wr_fail_s      = 1'b0;
        arb_en_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arb_en_s = 1'b1;
                case (gnt_s)
                    GNT_WR: begin
                        op_rd_d = 1'b0;
                        if (inFifoFull) begin
                            hold_consume_s = 1'b1;
                            wr_fail_s      = 1'b1;
                            state_d        = ST_GAP;
                        end else begin
                            wr_en_d    = 1'b1;
                            fifo_bit_d = hold_bit_q;
                            state_d    = ST_ISSUE_WR;
                        end
                    end
                    GNT_RD: begin
                        op_rd_d = 1'b1;
                        if (inFifoEmpty) begin
                            rd_fail_d = 1'b1;
                            state_d   = ST_RESP;
                        end else begin
                            rd_fail_d = 1'b0;
                            rd_en_d   = 1'b1;
                            state_d   = ST_ISSUE_RD;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_ISSUE_WR, ST_ISSUE_RD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (inFifoDone) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    if (op_rd_q) begin
                        rd_data_d = inFifoData;
                        rd_fail_d = 1'b0;
                        state_d   = ST_RESP;
                    end else begin
                        hold_consume_s = 1'b1;
                        state_d        = ST_GAP;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    if (op_rd_q) begin
                        rd_fail_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        hold_consume_s = 1'b1;
                        wr_fail_s      = 1'b1;
                        state_d        = ST_GAP;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                wr_en_d = 1'b0;
                rd_en_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register, sticky overrun, error counter and response flags.
    always_comb begin
        bit_take_s  = inBitValid & (~hold_full_q | hold_consume_s);
        bit_drop_s  = inBitValid & hold_full_q & ~hold_consume_s;
        hold_bit_d  = bit_take_s ? inBit : hold_bit_q;
        if (bit_take_s) begin
            hold_full_d = 1'b1;
        end else if (hold_consume_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end
        overrun_d = bit_drop_s | (overrun_q & ~inClearErr);
        err_cnt_d = wr_fail_s ? sat_inc8(err_cnt_q) : err_cnt_q;
        rd_ack_d  = (state_q == ST_RESP);
        rd_err_d  = (state_q == ST_RESP) & rd_fail_q;
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers; async reset drops the enables at once.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            state_q     <= ST_IDLE;
            op_rd_q     <= 1'b0;
            tmo_cnt_q   <= '0;
            hold_full_q <= 1'b0;
            hold_bit_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            fifo_bit_q  <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_err_q    <= 1'b0;
            rd_fail_q   <= 1'b0;
            rd_data_q   <= '0;
            overrun_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_rd_q     <= op_rd_d;
            tmo_cnt_q   <= tmo_cnt_d;
            hold_full_q <= hold_full_d;
            hold_bit_q  <= hold_bit_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            fifo_bit_q  <= fifo_bit_d;
            rd_ack_q    <= rd_ack_d;
            rd_err_q    <= rd_err_d;
            rd_fail_q   <= rd_fail_d;
            rd_data_q   <= rd_data_d;
            overrun_q   <= overrun_d;
            err_cnt_q   <= err_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign outFifoWrEn   = wr_en_q;
    assign outFifoRdEn   = rd_en_q;
    assign outFifoBit    = fifo_bit_q;
    assign outRdAck      = rd_ack_q;
    assign outRdErr      = rd_err_q;
    assign outRdData     = rd_data_q;
    assign outBitOverrun = overrun_q;
    assign outWrErrCnt   = err_cnt_q;
    assign outBusy       = busy_q;

endmodule
